// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: RISC-V encodings, register index width,
// hazard FSM states, scoreboard entry and stage-control bundles.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [6:0]  OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0]  OPC_STORE  = 7'b010_0011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0]  OPC_OP     = 7'b011_0011;
  localparam logic [6:0]  OPC_BRANCH = 7'b110_0011;
  localparam logic [2:0]  F3_ADD_SUB = 3'b000;
  localparam logic [6:0]  F7_SUB     = 7'b010_0000;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             ld;
  } sb_entry_t;

  typedef struct packed {
    logic pc_ena;
    logic if_id_ena;
    logic if_id_x;
    logic id_ex_x;
  } stg_ctrl_t;

  localparam stg_ctrl_t CTRL_RUN   = '{pc_ena: 1'b1, if_id_ena: 1'b1, if_id_x: 1'b0, id_ex_x: 1'b0};
  localparam stg_ctrl_t CTRL_STALL = '{pc_ena: 1'b0, if_id_ena: 1'b0, if_id_x: 1'b0, id_ex_x: 1'b1};
  localparam stg_ctrl_t CTRL_FLUSH = '{pc_ena: 1'b1, if_id_ena: 1'b1, if_id_x: 1'b1, id_ex_x: 1'b1};
  localparam stg_ctrl_t CTRL_RESET = '{pc_ena: 1'b0, if_id_ena: 1'b0, if_id_x: 1'b1, id_ex_x: 1'b1};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side view of the hazard controller: ID operand info and branch
// redirect in, stage latch controls and performance counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import hazard_ctrl_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [REG_W-1:0] id_rd;
  logic             id_save_to_reg;
  logic             id_rd_memory;
  logic             ex_branch_taken;

  logic             pc_ena;
  logic             if_id_ena;
  logic             if_id_x;
  logic             id_ex_x;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_save_to_reg, id_rd_memory, ex_branch_taken,
    input  pc_ena, if_id_ena, if_id_x, id_ex_x, stall_cycles, flush_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_save_to_reg, id_rd_memory, ex_branch_taken,
    output pc_ena, if_id_ena, if_id_x, id_ex_x, stall_cycles, flush_cycles
  );

endinterface

// File: rtl/hazard_ctrl_sb_match.sv
// Compares one in-flight destination against the ID-stage sources.
module hazard_ctrl_sb_match
  import hazard_ctrl_pkg::*;
(
  input  logic             v,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  output logic             hit
);

  // x0 is hard-wired zero, so it can never carry a dependency.
  assign hit = v && (rd != '0) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: scoreboards destinations downstream of ID to
// generate load-use / RAW stalls, and squashes IF/ID + ID/EX after taken branches.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter bit FWD_EN   = 1'b1,
  parameter int DEPTH    = 3,
  parameter int BR_FLUSH = 1,
  parameter int CNT_W    = 32
) (
  input  logic         stg_clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  // Only sb[0] matters with forwarding; without it, everything but the
  // entry writing the regfile this cycle (write-before-read) can stall.
  localparam logic [DEPTH-1:0] HIT_MASK = FWD_EN ? DEPTH'(1) : DEPTH'((1 << (DEPTH - 1)) - 1);
  // Branch cycle itself is the first flush cycle; FLUSH covers the rest.
  localparam logic [1:0] FLUSH_LOAD = (BR_FLUSH > 1) ? 2'(BR_FLUSH - 2) : 2'd0;

  sb_entry_t        sb [DEPTH];
  logic [DEPTH-1:0] hit;
  logic [DEPTH-1:0] ld_vec;
  hz_state_e        state;
  logic [1:0]       flush_cnt;
  logic             raw;
  logic             flush_now;
  logic             stall_now;
  stg_ctrl_t        ctrl;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt_perf;

  for (genvar k = 0; k < DEPTH; k++) begin : g_match
    hazard_ctrl_sb_match u_match (
      .v        (sb[k].v),
      .rd       (sb[k].rd),
      .rs1      (hz.id_rs1),
      .rs2      (hz.id_rs2),
      .rs1_used (hz.id_rs1_used),
      .rs2_used (hz.id_rs2_used),
      .hit      (hit[k])
    );
    assign ld_vec[k] = sb[k].ld;
  end

  assign raw       = |(hit & HIT_MASK & (FWD_EN ? ld_vec : '1));
  assign flush_now = hz.ex_branch_taken || (state == ST_FLUSH);
  assign stall_now = !flush_now && raw && hz.id_valid;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    ctrl = CTRL_RUN;
    if (reset)          ctrl = CTRL_RESET;
    else if (flush_now) ctrl = CTRL_FLUSH;
    else if (stall_now) ctrl = CTRL_STALL;
  end

  assign hz.pc_ena    = ctrl.pc_ena;
  assign hz.if_id_ena = ctrl.if_id_ena;
  assign hz.if_id_x   = ctrl.if_id_x;
  assign hz.id_ex_x   = ctrl.id_ex_x;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; this is what makes the sb[k] <= sb[k-1] shift correct.
  // NOTE: the scoreboard is a handful of flops, not a RAM, and its valid bits
  // must start clear, so every entry is reset.
  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
    end else begin
      sb[0] <= '{v:  hz.id_valid && hz.id_save_to_reg && (hz.id_rd != '0) &&
                     !(flush_now || stall_now),
                 rd: hz.id_rd,
                 ld: hz.id_rd_memory};
      for (int k = 1; k < DEPTH; k++) sb[k] <= sb[k-1];
    end
  end

  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hz.ex_branch_taken && (BR_FLUSH > 1)) begin
            state     <= ST_FLUSH;
            flush_cnt <= FLUSH_LOAD;
          end
        end
        ST_FLUSH: begin
          if (hz.ex_branch_taken)  flush_cnt <= FLUSH_LOAD;
          else if (flush_cnt == 0) state     <= ST_RUN;
          else                     flush_cnt <= flush_cnt - 2'd1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      stall_cnt      <= '0;
      flush_cnt_perf <= '0;
    end else begin
      if (stall_now && (stall_cnt != '1))      stall_cnt      <= stall_cnt + CNT_W'(1);
      if (flush_now && (flush_cnt_perf != '1)) flush_cnt_perf <= flush_cnt_perf + CNT_W'(1);
    end
  end

  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_cycles = flush_cnt_perf;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: two controllers (forwarding/BR_FLUSH=1/CNT_W=4 and
// no-forwarding/BR_FLUSH=2) driven with identical ID-stage streams.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  // {pc_ena, if_id_ena, if_id_x, id_ex_x}
  localparam logic [3:0] C_RUN   = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_FLUSH = 4'b1111;
  localparam logic [3:0] C_RESET = 4'b0011;
  localparam int         N_VEC   = 28;

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       br;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
  } vec_t;

  logic stg_clk = 1'b0;
  logic reset;
  always #5 stg_clk = ~stg_clk;

  hazard_ctrl_if #(.CNT_W(4))  ifa ();
  hazard_ctrl_if #(.CNT_W(32)) ifb ();

  hazard_ctrl #(.FWD_EN(1'b1), .DEPTH(3), .BR_FLUSH(1), .CNT_W(4)) u_dut_a (
    .stg_clk (stg_clk),
    .reset   (reset),
    .hz      (ifa)
  );

  hazard_ctrl #(.FWD_EN(1'b0), .DEPTH(3), .BR_FLUSH(2), .CNT_W(32)) u_dut_b (
    .stg_clk (stg_clk),
    .reset   (reset),
    .hz      (ifb)
  );

  logic [3:0] ctrl_a, ctrl_b;
  assign ctrl_a = {ifa.pc_ena, ifa.if_id_ena, ifa.if_id_x, ifa.id_ex_x};
  assign ctrl_b = {ifb.pc_ena, ifb.if_id_ena, ifb.if_id_x, ifb.id_ex_x};

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl [N_VEC];

  function automatic vec_t mk(logic valid, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic [4:0] rd, logic wr, logic ld, logic br,
                              logic [3:0] exp_a, logic [3:0] exp_b);
    vec_t v;
    v.valid = valid; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.rd = rd; v.wr = wr; v.ld = ld; v.br = br; v.exp_a = exp_a; v.exp_b = exp_b;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    ifa.id_valid = v.valid;  ifa.id_rs1 = v.rs1;  ifa.id_rs1_used = v.u1;
    ifa.id_rs2 = v.rs2;      ifa.id_rs2_used = v.u2;
    ifa.id_rd = v.rd;        ifa.id_save_to_reg = v.wr;
    ifa.id_rd_memory = v.ld; ifa.ex_branch_taken = v.br;
    ifb.id_valid = v.valid;  ifb.id_rs1 = v.rs1;  ifb.id_rs1_used = v.u1;
    ifb.id_rs2 = v.rs2;      ifb.id_rs2_used = v.u2;
    ifb.id_rd = v.rd;        ifb.id_save_to_reg = v.wr;
    ifb.id_rd_memory = v.ld; ifb.ex_branch_taken = v.br;
  endtask

  // Inputs land just after a rising edge; outputs are sampled on the falling edge.
  task automatic apply_check(vec_t v, string tag);
    drive(v);
    @(negedge stg_clk);
    check({tag, "/ctrl_a"}, 32'(ctrl_a), 32'(v.exp_a));
    check({tag, "/ctrl_b"}, 32'(ctrl_b), 32'(v.exp_b));
    @(posedge stg_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t idle, lw5, use5, br_idle;
    idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   C_RUN);
    lw5     = mk(1, 1, 1, 0, 0, 5, 1, 1, 0, C_RUN,   C_RUN);
    use5    = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, C_STALL, C_STALL);
    br_idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, C_FLUSH, C_FLUSH);

    // Load-use: forwarding stalls once, no-forwarding stalls until lw reaches sb[2].
    tbl[0]  = lw5;
    tbl[1]  = use5;
    tbl[2]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, C_RUN, C_STALL);
    tbl[3]  = idle;
    tbl[4]  = idle;
    tbl[5]  = idle;
    // ALU RAW: forwarded for A; B stalls two cycles, sb[2] write-before-read is free.
    tbl[6]  = mk(1, 1, 1, 2, 1, 5, 1, 0, 0, C_RUN, C_RUN);
    tbl[7]  = mk(1, 5, 1, 2, 1, 7, 1, 0, 0, C_RUN, C_STALL);
    tbl[8]  = mk(1, 5, 1, 2, 1, 7, 1, 0, 0, C_RUN, C_STALL);
    tbl[9]  = mk(1, 5, 1, 2, 1, 7, 1, 0, 0, C_RUN, C_RUN);
    tbl[10] = idle;
    tbl[11] = idle;
    tbl[12] = idle;
    // x0 destination, unused rs2 field, and invalid ID never stall.
    tbl[13] = mk(1, 1, 1, 0, 0, 0, 1, 1, 0, C_RUN, C_RUN);
    tbl[14] = mk(1, 0, 1, 0, 1, 3, 1, 0, 0, C_RUN, C_RUN);
    tbl[15] = mk(1, 1, 1, 0, 0, 8, 1, 1, 0, C_RUN, C_RUN);
    tbl[16] = mk(1, 1, 1, 8, 0, 9, 1, 0, 0, C_RUN, C_RUN);
    tbl[17] = mk(0, 8, 1, 8, 1, 0, 0, 0, 0, C_RUN, C_RUN);
    tbl[18] = idle;
    tbl[19] = idle;
    // Branch beats load-use; B flushes for two cycles.
    tbl[20] = lw5;
    tbl[21] = mk(1, 5, 1, 1, 1, 6, 1, 0, 1, C_FLUSH, C_FLUSH);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, C_FLUSH);
    tbl[23] = idle;
    // Second branch during FLUSH reloads the count.
    tbl[24] = br_idle;
    tbl[25] = br_idle;
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, C_FLUSH);
    tbl[27] = idle;

    reset = 1'b1;
    drive(idle);
    @(negedge stg_clk);
    check("reset/ctrl_a", 32'(ctrl_a), 32'(C_RESET));
    check("reset/ctrl_b", 32'(ctrl_b), 32'(C_RESET));
    check("reset/stall_a", 32'(ifa.stall_cycles), 0);
    check("reset/flush_b", ifb.flush_cycles, 0);
    reset = 1'b0;
    @(posedge stg_clk);
    #1;

    for (int i = 0; i < N_VEC; i++) apply_check(tbl[i], $sformatf("vec%0d", i));

    check("tbl/stall_a", 32'(ifa.stall_cycles), 1);
    check("tbl/flush_a", 32'(ifa.flush_cycles), 3);
    check("tbl/stall_b", ifb.stall_cycles, 4);
    check("tbl/flush_b", ifb.flush_cycles, 5);

    // Twenty load-use pairs: the 4-bit counter must saturate at 15.
    for (int p = 0; p < 20; p++) begin
      apply_check(lw5,  $sformatf("sat%0d/lw", p));
      apply_check(use5, $sformatf("sat%0d/use", p));
    end
    check("sat/stall_a", 32'(ifa.stall_cycles), 15);
    check("sat/stall_b", ifb.stall_cycles, 24);
    check("sat/flush_a", 32'(ifa.flush_cycles), 3);

    // Reset while B sits in FLUSH with a live load in the scoreboard.
    apply_check(lw5, "rst/lw");
    apply_check(br_idle, "rst/br");
    drive(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, C_RUN, C_RUN));
    #1;
    check("rst/pre_b_flush", 32'(ctrl_b), 32'(C_FLUSH));
    check("rst/pre_a_run", 32'(ctrl_a), 32'(C_RUN));
    reset = 1'b1;
    #1;
    check("rst/ctrl_a", 32'(ctrl_a), 32'(C_RESET));
    check("rst/ctrl_b", 32'(ctrl_b), 32'(C_RESET));
    check("rst/stall_a", 32'(ifa.stall_cycles), 0);
    check("rst/flush_a", 32'(ifa.flush_cycles), 0);
    check("rst/stall_b", ifb.stall_cycles, 0);
    check("rst/flush_b", ifb.flush_cycles, 0);
    repeat (2) @(posedge stg_clk);
    @(negedge stg_clk);
    reset = 1'b0;
    #1;
    check("post/ctrl_a", 32'(ctrl_a), 32'(C_RUN));
    check("post/ctrl_b", 32'(ctrl_b), 32'(C_RUN));
    @(posedge stg_clk);
    #1;
    apply_check(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, C_RUN, C_RUN), "post/use");
    check("post/stall_b", ifb.stall_cycles, 0);
    check("post/flush_b", ifb.flush_cycles, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
